dla_regif_buf_mask_gen: RTL and testbench

//  Parametrised buffer-mask register file and stager for the DLA global buffer.

---
 rtl/dla_regif_buf_mask_gen_pkg.sv | 37 +++
 rtl/dla_buf_mask_stage.sv | 47 ++++
 rtl/dla_regif_buf_mask_gen.sv | 129 ++++++++++++
 tb/tb_dla_regif_buf_mask_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dla_regif_buf_mask_gen_pkg.sv
// Shared types and register map for the DLA global-buffer mask register file.
// Holds the mask modes, stager op codes, CTRL register layout and address map.
package dla_regif_buf_mask_gen_pkg;

    typedef enum logic [1:0] {
        BMM_DIRECT = 2'b00,
        BMM_CLONE  = 2'b01,
        BMM_ROTATE = 2'b10
    } buf_mask_mode_e;

    typedef enum logic [2:0] {
        OP_IDLE       = 3'd0,
        OP_MOV_SOC2GB = 3'd1,
        OP_MOV_GB2PE  = 3'd2,
        OP_COMPUTE    = 3'd3
    } status_e;

    typedef struct packed {
        logic [1:0]  mode;
        logic [5:0]  rsvd;
        logic [7:0]  rot_cnt;
        logic [15:0] clone_mask;
    } reg_buf_mask_ctrl_t;

    localparam int BUF_MASK_CTRL_ADDR = 0;
    localparam int BUF_MASK_DATA_BASE = 1;

    // Encoding 2'b11 is not a valid mode and is stored as DIRECT.
    function automatic buf_mask_mode_e decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return BMM_CLONE;
            2'b10:   return BMM_ROTATE;
            default: return BMM_DIRECT;
        endcase
    endfunction

endpackage

// File: rtl/dla_buf_mask_stage.sv
// Staging register for the buffer mask: loads on go, rotates left by one group
// per enabled step, and counts the groups rotated since the last load.
module dla_buf_mask_stage #(
    parameter int NUM_GRP = 16,
    parameter int MASK_W  = 16,
    localparam int W      = NUM_GRP * MASK_W,
    localparam int CW     = $clog2(NUM_GRP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          step_en,
    input  logic [W-1:0]  unstaging,
    output logic [W-1:0]  staging,
    output logic [CW-1:0] rot_cnt
);

    logic [W-1:0]  staging_q, staging_d;
    logic [CW-1:0] rot_cnt_q, rot_cnt_d;

    // go has priority; a step arriving with go is dropped.
    always_comb begin
        staging_d = staging_q;
        rot_cnt_d = rot_cnt_q;
        if (go) begin
            staging_d = unstaging;
            rot_cnt_d = '0;
        end else if (step_en) begin
            staging_d = {staging_q[W-MASK_W-1:0], staging_q[W-1 -: MASK_W]};
            rot_cnt_d = rot_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            staging_q <= '0;
            rot_cnt_q <= '0;
        end else begin
            staging_q <= staging_d;
            rot_cnt_q <= rot_cnt_d;
        end
    end

    assign staging = staging_q;
    assign rot_cnt = rot_cnt_q;

endmodule

// File: rtl/dla_regif_buf_mask_gen.sv
// Buffer-mask register file: CTRL and DATA registers on the regif bus, mode-dependent
// unstaged mask, staging sub-block and the SOC2GB bypass to the stager.
module dla_regif_buf_mask_gen
    import dla_regif_buf_mask_gen_pkg::*;
#(
    parameter int NUM_GRP = 16,
    parameter int MASK_W  = 16,
    parameter int AW      = 4,
    localparam int GPR    = 32 / MASK_W,
    localparam int NDATA  = NUM_GRP / GPR,
    localparam int W      = NUM_GRP * MASK_W,
    localparam int CW     = $clog2(NUM_GRP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic          step,
    input  status_e       stgr_status,
    output logic [W-1:0]  stgr_buf_mask,
    output logic [CW-1:0] rot_cnt,
    input  logic          reg_wen,
    input  logic [AW-1:0] reg_addr,
    input  logic [31:0]   regif_wdata,
    output logic [31:0]   reg_rdata,
    output logic          wr_err
);

    buf_mask_mode_e     mode_q, mode_d;
    logic [MASK_W-1:0]  clone_q, clone_d;
    logic               wr_err_q, wr_err_d;
    logic [W-1:0]       data_flat;
    logic [W-1:0]       unstaging;
    logic [W-1:0]       staging;
    logic               ctrl_sel;
    logic               addr_oor;
    reg_buf_mask_ctrl_t ctrl_rd;

    assign ctrl_sel = (int'(reg_addr) == BUF_MASK_CTRL_ADDR);
    assign addr_oor = (int'(reg_addr) > NDATA);

    // DATA words pack straight into the flat mask: group 0 lands at the LSBs.
    for (genvar gi = 0; gi < NDATA; gi++) begin : g_data
        logic [31:0] data_q, data_d;

        always_comb begin
            data_d = data_q;
            if (reg_wen && int'(reg_addr) == BUF_MASK_DATA_BASE + gi) begin
                data_d = regif_wdata;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign data_flat[gi*32 +: 32] = data_q;
    end

    always_comb begin
        mode_d   = mode_q;
        clone_d  = clone_q;
        wr_err_d = reg_wen && addr_oor;
        if (reg_wen && ctrl_sel) begin
            mode_d  = decode_mode(regif_wdata[31:30]);
            clone_d = regif_wdata[MASK_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= BMM_DIRECT;
            clone_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            clone_q  <= clone_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        ctrl_rd            = '0;
        ctrl_rd.mode       = mode_q;
        ctrl_rd.rot_cnt    = 8'(rot_cnt);
        ctrl_rd.clone_mask = 16'(clone_q);
    end

    always_comb begin
        reg_rdata = '0;
        if (ctrl_sel) begin
            reg_rdata = ctrl_rd;
        end else if (!addr_oor) begin
            for (int k = 0; k < NDATA; k++) begin
                if (int'(reg_addr) == BUF_MASK_DATA_BASE + k) begin
                    reg_rdata = data_flat[k*32 +: 32];
                end
            end
        end
    end

    always_comb begin
        unstaging = data_flat;
        if (mode_q == BMM_CLONE) begin
            unstaging = {NUM_GRP{clone_q}};
        end
    end

    dla_buf_mask_stage #(
        .NUM_GRP (NUM_GRP),
        .MASK_W  (MASK_W)
    ) u_stage (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .step_en   (step && (mode_q == BMM_ROTATE)),
        .unstaging (unstaging),
        .staging   (staging),
        .rot_cnt   (rot_cnt)
    );

    // SOC2GB moves see register contents immediately, without a go.
    assign stgr_buf_mask = (stgr_status == OP_MOV_SOC2GB) ? unstaging : staging;
    assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_dla_regif_buf_mask_gen.sv
// Directed bench: a 16x16 instance and an 8x8 instance share one stimulus stream.
module tb_dla_regif_buf_mask_gen;
    import dla_regif_buf_mask_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        step = 1'b0;
    status_e     status = OP_IDLE;
    logic        wen = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;

    logic [255:0] a_mask;
    logic [3:0]   a_rot;
    logic [31:0]  a_rdata;
    logic         a_err;
    logic [63:0]  b_mask;
    logic [2:0]   b_rot;
    logic [31:0]  b_rdata;
    logic         b_err;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dla_regif_buf_mask_gen dut_a (
        .clk(clk), .rst(rst), .go(go), .step(step), .stgr_status(status),
        .stgr_buf_mask(a_mask), .rot_cnt(a_rot), .reg_wen(wen), .reg_addr(addr),
        .regif_wdata(wdata), .reg_rdata(a_rdata), .wr_err(a_err)
    );

    dla_regif_buf_mask_gen #(.NUM_GRP(8), .MASK_W(8), .AW(4)) dut_b (
        .clk(clk), .rst(rst), .go(go), .step(step), .stgr_status(status),
        .stgr_buf_mask(b_mask), .rot_cnt(b_rot), .reg_wen(wen), .reg_addr(addr),
        .regif_wdata(wdata), .reg_rdata(b_rdata), .wr_err(b_err)
    );

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        wen = 1'b1;
        addr = a;
        wdata = d;
        tick();
        wen = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    logic [255:0] a_exp;
    logic [63:0]  b_exp;
    logic [255:0] one_a;
    logic [63:0]  one_b;
    logic [31:0]  w;
    logic [31:0]  w1;
    logic [31:0]  w8;
    logic [3:0]   kn;
    logic [3:0]   kh;

    initial begin
        vt[0] = '{4'd0,  32'hC000_1234, 32'h0000_1234, 1'b0};
        vt[1] = '{4'd0,  32'h40FF_A5A5, 32'h4000_A5A5, 1'b0};
        vt[2] = '{4'd0,  32'hBFFF_0000, 32'h8000_0000, 1'b0};
        vt[3] = '{4'd3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vt[4] = '{4'd8,  32'h1234_5678, 32'h1234_5678, 1'b0};
        vt[5] = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        vt[6] = '{4'd15, 32'h0000_0001, 32'h0000_0000, 1'b1};
        one_a = 256'd1;
        one_b = 64'd1;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_err_a", 256'(a_err), 256'd0);
        chk("rst_rot_a", 256'(a_rot), 256'd0);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            #1;
            chk($sformatf("rst_rd_a[%0d]", i), 256'(a_rdata), 256'd0);
            chk($sformatf("rst_rd_b[%0d]", i), 256'(b_rdata), 256'd0);
        end
        pulse_go();
        chk("rst_go_mask_a", a_mask, 256'd0);
        chk("rst_go_mask_b", 256'(b_mask), 256'd0);

        // Register table: readback after write, wr_err pulse on out-of-range
        for (int i = 0; i < 7; i++) begin
            wr(vt[i].addr, vt[i].wdata);
            chk($sformatf("tbl%0d_rdata", i), 256'(a_rdata), 256'(vt[i].exp_rdata));
            chk($sformatf("tbl%0d_err", i), 256'(a_err), 256'(vt[i].exp_err));
            tick();
            chk($sformatf("tbl%0d_err_clr", i), 256'(a_err), 256'd0);
        end

        // DIRECT
        wr(4'd0, 32'h0000_0000);
        a_exp = '0;
        b_exp = '0;
        for (int k = 1; k <= 8; k++) begin
            kn = 4'(k);
            kh = 4'(k + 8);
            w = {kn, kh, kn, kh, kn, kh, kn, kh};
            if (k == 1) w1 = w;
            if (k == 8) w8 = w;
            a_exp[(k-1)*32 +: 32] = w;
            if (k <= 2) b_exp[(k-1)*32 +: 32] = w;
            wr(4'(k), w);
        end
        chk("direct_premask_a", a_mask, 256'd0);
        pulse_go();
        chk("direct_lo_a", 256'(a_mask[15:0]), 256'(w1[15:0]));
        chk("direct_hi_a", 256'(a_mask[255:240]), 256'(w8[31:16]));
        chk("direct_mask_a", a_mask, a_exp);
        chk("direct_mask_b", 256'(b_mask), 256'(b_exp));

        // CLONE: go captures pre-write CTRL
        wr(4'd0, 32'h4000_A5A5);
        go = 1'b1;
        wen = 1'b1;
        addr = 4'd0;
        wdata = 32'h4000_0F0F;
        tick();
        go = 1'b0;
        wen = 1'b0;
        chk("clone_mask_a", a_mask, {16{16'hA5A5}});
        chk("clone_mask_b", 256'(b_mask), 256'({8{8'hA5}}));
        chk("clone_ctrl_rd", 256'(a_rdata), 256'(32'h4000_0F0F));
        pulse_go();
        chk("clone_rego_a", a_mask, {16{16'h0F0F}});

        // ROTATE
        wr(4'd1, 32'h0000_0001);
        for (int k = 2; k <= 8; k++) wr(4'(k), 32'h0);
        wr(4'd0, 32'h8000_0000);
        pulse_go();
        chk("rot0_mask_a", a_mask, one_a);
        chk("rot0_mask_b", 256'(b_mask), 256'(one_b));
        for (int n = 1; n <= 16; n++) begin
            pulse_step();
            chk($sformatf("rot%0d_mask_a", n), a_mask, one_a << (16 * (n % 16)));
            chk($sformatf("rot%0d_cnt_a", n), 256'(a_rot), 256'(n % 16));
            chk($sformatf("rot%0d_mask_b", n), 256'(b_mask), 256'(one_b << (8 * (n % 8))));
            chk($sformatf("rot%0d_cnt_b", n), 256'(b_rot), 256'(n % 8));
            if (n == 5) begin
                addr = 4'd0;
                #1;
                chk("rot5_ctrl_rd", 256'(a_rdata), 256'(32'h8005_0000));
            end
        end

        // go + step together, then step outside ROTATE
        repeat (3) pulse_step();
        chk("pre_gostep_cnt_a", 256'(a_rot), 256'd3);
        go = 1'b1;
        step = 1'b1;
        tick();
        go = 1'b0;
        step = 1'b0;
        chk("gostep_mask_a", a_mask, one_a);
        chk("gostep_cnt_a", 256'(a_rot), 256'd0);
        repeat (2) pulse_step();
        wr(4'd0, 32'h0000_0000);
        chk("modechg_mask_a", a_mask, one_a << 32);
        chk("modechg_cnt_a", 256'(a_rot), 256'd2);
        pulse_step();
        chk("direct_step_mask_a", a_mask, one_a << 32);
        chk("direct_step_cnt_a", 256'(a_rot), 256'd2);
        chk("direct_step_mask_b", 256'(b_mask), 256'(one_b << 16));

        // Bypass
        status = OP_MOV_SOC2GB;
        #1;
        chk("byp_now_a", a_mask, one_a);
        wr(4'd1, 32'hCAFE_F00D);
        chk("byp_follow_a", a_mask, 256'(32'hCAFE_F00D));
        chk("byp_follow_b", 256'(b_mask), 256'(32'hCAFE_F00D));
        status = OP_IDLE;
        #1;
        chk("byp_leave_a", a_mask, one_a << 32);
        chk("byp_leave_b", 256'(b_mask), 256'(one_b << 16));

        // Reset mid-rotation with a step pending
        wr(4'd0, 32'h8000_0000);
        pulse_go();
        repeat (2) pulse_step();
        chk("prerst_cnt_a", 256'(a_rot), 256'd2);
        rst = 1'b1;
        step = 1'b1;
        tick();
        rst = 1'b0;
        step = 1'b0;
        chk("midrst_mask_a", a_mask, 256'd0);
        chk("midrst_cnt_a", 256'(a_rot), 256'd0);
        chk("midrst_mask_b", 256'(b_mask), 256'd0);
        chk("midrst_cnt_b", 256'(b_rot), 256'd0);
        addr = 4'd0;
        tick();
        chk("midrst_ctrl_rd", 256'(a_rdata), 256'd0);
        chk("midrst_cnt_hold_a", 256'(a_rot), 256'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
